fetch_stage: RTL and testbench

//   Instruction-fetch stage plus IF/ID pipeline register: holds the PC, picks the next PC from the
//   ID-stage redirect select, drives a 1-cycle-latency instruction memory, and delivers dpc/dinst
//   to the decode/control logic. Obeys pcStall/ifidStall and flushes wrong-path fetches with a NOP.

---
 rtl/fetch_stage_pkg.sv | 21 ++
 rtl/fetch_stage_ifid_reg.sv | 35 +++
 rtl/fetch_stage.sv | 109 ++++++++++
 tb/tb_fetch_stage.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: next-PC select encodings, NOP bubble, word alignment helper.
package fetch_stage_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    PCSEL_SEQ    = 2'b00,
    PCSEL_BRANCH = 2'b01,
    PCSEL_JUMP   = 2'b10,
    PCSEL_TRAP   = 2'b11
  } pcsel_e;

  localparam logic [XLEN-1:0] NOP_INST_DEF     = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] TRAP_VECTOR_DEF  = 32'h0000_0100;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: reset beats flush, flush beats stall, stall beats load.
import fetch_stage_pkg::*;

module ifid_reg #(
  parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            stall,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] dpc,
  output logic [XLEN-1:0] dinst,
  output logic            dvalid
);

  // dvalid=1 means dpc/dinst name a real on-path instruction; a bubble carries NOP with dvalid=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      dpc    <= '0;
      dinst  <= NOP_INST;
      dvalid <= 1'b0;
    end else if (flush) begin
      dpc    <= pc;
      dinst  <= NOP_INST;
      dvalid <= 1'b0;
    end else if (!stall) begin
      dpc    <= pc;
      dinst  <= inst;
      dvalid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC mux, imem request and IF/ID register.
// Optional event counters are built only when FETCH_PERF_EN is defined.
import fetch_stage_pkg::*;

module fetch_stage #(
  parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = TRAP_VECTOR_DEF,
  parameter logic [XLEN-1:0] NOP_INST     = NOP_INST_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      pcSel,
  input  logic            pcStall,
  input  logic            ifidStall,
  input  logic [XLEN-1:0] bTarget,
  input  logic [XLEN-1:0] jTarget,
  output logic [XLEN-1:0] imemAddr,
  output logic            imemEn,
  input  logic [XLEN-1:0] imemRdata,
  output logic [XLEN-1:0] fpc,
  output logic [XLEN-1:0] dpc,
  output logic [XLEN-1:0] dinst,
  output logic            dvalid,
  output logic [XLEN-1:0] perfFetched,
  output logic [XLEN-1:0] perfStalls,
  output logic [XLEN-1:0] perfFlushes
);

  logic [XLEN-1:0] fpc_q;
  logic [XLEN-1:0] next_pc;
  logic            redirect;

  always_comb begin
    next_pc = align_word(fpc_q + 32'd4);
    case (pcSel)
      PCSEL_SEQ:    next_pc = align_word(fpc_q + 32'd4);
      PCSEL_BRANCH: next_pc = align_word(bTarget);
      PCSEL_JUMP:   next_pc = align_word(jTarget);
      PCSEL_TRAP:   next_pc = align_word(TRAP_VECTOR);
      default:      next_pc = align_word(fpc_q + 32'd4);
    endcase
  end

  // A stall freezes the PC, so a redirect presented during a stall is dropped here.
  assign redirect = (pcSel != PCSEL_SEQ) && !pcStall;

  // Holding the address and dropping the enable keeps the imem output on fpc's word.
  assign imemAddr = rst ? RESET_VECTOR : (pcStall ? fpc_q : next_pc);
  assign imemEn   = rst | ~pcStall;
  assign fpc      = fpc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fpc_q <= RESET_VECTOR;
    end else if (!pcStall) begin
      fpc_q <= next_pc;
    end
  end

  ifid_reg #(
    .NOP_INST (NOP_INST)
  ) u_ifid (
    .clk    (clk),
    .rst    (rst),
    .flush  (redirect),
    .stall  (ifidStall),
    .pc     (fpc_q),
    .inst   (imemRdata),
    .dpc    (dpc),
    .dinst  (dinst),
    .dvalid (dvalid)
  );

  // Holding IF/ID while the PC advances drops a fetched word; only a redirect makes that safe.
  ifid_hold_only_on_redirect: assert property (
    @(posedge clk) disable iff (rst)
      !(ifidStall && !pcStall && (pcSel == PCSEL_SEQ))
  );

`ifdef FETCH_PERF_EN
  logic [XLEN-1:0] fetched_q;
  logic [XLEN-1:0] stalls_q;
  logic [XLEN-1:0] flushes_q;
  logic            fetch_evt;

  assign fetch_evt = !redirect && !ifidStall;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetched_q <= '0;
      stalls_q  <= '0;
      flushes_q <= '0;
    end else begin
      if (fetch_evt) fetched_q <= fetched_q + 32'd1;
      if (pcStall)   stalls_q  <= stalls_q + 32'd1;
      if (redirect)  flushes_q <= flushes_q + 32'd1;
    end
  end

  assign perfFetched = fetched_q;
  assign perfStalls  = stalls_q;
  assign perfFlushes = flushes_q;
`else
  assign perfFetched = '0;
  assign perfStalls  = '0;
  assign perfFlushes = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then randomized control, checked against a rule-level model.
module tb_fetch_stage;

  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [31:0] TV  = 32'h0000_0100;
  localparam logic [31:0] NOP = 32'h0000_0013;

  // clock / reset block
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pcSel;
  logic        pcStall;
  logic        ifidStall;
  logic [31:0] bTarget;
  logic [31:0] jTarget;
  logic [31:0] imemAddr;
  logic        imemEn;
  logic [31:0] imemRdata = 32'h0;
  logic [31:0] fpc, dpc, dinst;
  logic        dvalid;
  logic [31:0] perfFetched, perfStalls, perfFlushes;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .pcSel       (pcSel),
    .pcStall     (pcStall),
    .ifidStall   (ifidStall),
    .bTarget     (bTarget),
    .jTarget     (jTarget),
    .imemAddr    (imemAddr),
    .imemEn      (imemEn),
    .imemRdata   (imemRdata),
    .fpc         (fpc),
    .dpc         (dpc),
    .dinst       (dinst),
    .dvalid      (dvalid),
    .perfFetched (perfFetched),
    .perfStalls  (perfStalls),
    .perfFlushes (perfFlushes)
  );

  // instruction memory: each word holds its own word index, one-cycle read latency
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {2'b00, a[31:2]};
  endfunction

  always @(posedge clk) if (imemEn) imemRdata <= word_of(imemAddr);

  // scoreboard
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // reference model: architectural view of the stage
  logic [31:0] m_fpc = 32'h0, m_dpc = 32'h0, m_dinst = NOP;
  logic        m_dvalid = 1'b0;
  logic [31:0] m_fet = 0, m_stl = 0, m_fls = 0;

  function automatic logic [31:0] model_next(input logic [1:0] sel, input logic [31:0] bt,
                                             input logic [31:0] jt);
    logic [31:0] t;
    case (sel)
      2'd0:    t = m_fpc + 32'd4;
      2'd1:    t = bt;
      2'd2:    t = jt;
      default: t = TV;
    endcase
    return t & 32'hFFFF_FFFC;
  endfunction

  task automatic model_edge(input logic r, input logic [1:0] sel, input logic ps, input logic is,
                            input logic [31:0] bt, input logic [31:0] jt);
    logic [31:0] nxt;
    logic        redir;
    if (r) begin
      m_fpc = RV; m_dpc = 0; m_dinst = NOP; m_dvalid = 0;
      m_fet = 0; m_stl = 0; m_fls = 0;
    end else begin
      nxt   = model_next(sel, bt, jt);
      redir = (sel != 2'd0) && !ps;
      if (redir) begin
        m_dpc = m_fpc; m_dinst = NOP; m_dvalid = 0; m_fls++;
      end else if (!is) begin
        m_dpc = m_fpc; m_dinst = word_of(m_fpc); m_dvalid = 1; m_fet++;
      end
      if (ps) m_stl++;
      if (!ps) m_fpc = nxt;
    end
    exp_q.push_back(m_fpc);
    exp_q.push_back(m_dpc);
    exp_q.push_back(m_dinst);
    exp_q.push_back({31'b0, m_dvalid});
`ifdef FETCH_PERF_EN
    exp_q.push_back(m_fet);
    exp_q.push_back(m_stl);
    exp_q.push_back(m_fls);
`else
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
`endif
  endtask

  task automatic compare_regs();
    check("fpc",          fpc,               exp_q.pop_front());
    check("dpc",          dpc,               exp_q.pop_front());
    check("dinst",        dinst,             exp_q.pop_front());
    check("dvalid",       {31'b0, dvalid},   exp_q.pop_front());
    check("perf_fetched", perfFetched,       exp_q.pop_front());
    check("perf_stalls",  perfStalls,        exp_q.pop_front());
    check("perf_flushes", perfFlushes,       exp_q.pop_front());
  endtask

  // driver: one clock cycle of control inputs, combinational checks then registered checks
  task automatic step(input logic r, input logic [1:0] sel, input logic ps, input logic is,
                      input logic [31:0] bt, input logic [31:0] jt);
    logic [31:0] exp_addr;
    rst = r; pcSel = sel; pcStall = ps; ifidStall = is; bTarget = bt; jTarget = jt;
    #1;
    exp_addr = r ? RV : (ps ? m_fpc : model_next(sel, bt, jt));
    check("imem_addr", imemAddr, exp_addr);
    check("imem_en", {31'b0, imemEn}, {31'b0, r | ~ps});
    @(posedge clk);
    model_edge(r, sel, ps, is, bt, jt);
    #1;
    compare_regs();
  endtask

  initial begin
    logic       r, ps, is;
    logic [1:0] sel;

    // reset, then sequential fetch from the reset vector
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 1, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0);

    // branch redirect to 0x40
    step(0, 1, 0, 0, 32'h40, 0);
    repeat (2) step(0, 0, 0, 0, 0, 0);

    // three-cycle stall
    repeat (3) step(0, 0, 1, 1, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0, 0);

    // jump presented during a stall is ignored, then re-presented
    step(0, 2, 1, 1, 0, 32'h80);
    step(0, 2, 0, 0, 0, 32'h80);
    step(0, 0, 0, 0, 0, 0);

    // wrap at the top of the address space and misaligned target
    step(0, 2, 0, 0, 0, 32'hFFFF_FFFF);
    step(0, 0, 0, 0, 0, 0);
    step(0, 2, 0, 0, 0, 32'h83);
    step(0, 0, 0, 0, 0, 0);

    // trap redirect together with ifidStall: flush wins
    step(0, 3, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // pcStall without ifidStall, then reset mid-stall
    step(0, 0, 1, 0, 0, 0);
    step(1, 2, 1, 1, 0, 32'h200);
    step(0, 0, 0, 0, 0, 0);

    // counter scenario: 10 fetches, 3 stall cycles, 2 redirects after a fresh reset
    step(1, 0, 0, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0, 0, 0);
    repeat (3) step(0, 0, 1, 1, 0, 0);
    step(0, 1, 0, 0, 32'h400, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0);
    step(0, 2, 0, 0, 0, 32'h800);
    repeat (2) step(0, 0, 0, 0, 0, 0);

    // randomized control
    for (int i = 0; i < 500; i++) begin
      r   = ($urandom_range(0, 59) == 0);
      ps  = ($urandom_range(0, 4) == 0);
      sel = ($urandom_range(0, 9) < 6) ? 2'd0 : 2'($urandom_range(1, 3));
      if (ps || sel != 2'd0) is = 1'($urandom_range(0, 1));
      else                   is = 1'b0;
      step(r, sel, ps, is, $urandom, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: run still active at %0t, required completion before 200000", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
